// File: rtl/mips_muldiv_unit_pkg.sv
// rtl/mips_muldiv_unit_pkg.sv - op encodings, FSM state codes and width default for the mul/div unit
package mips_muldiv_unit_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_op_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_iter_core.sv
// rtl/mips_muldiv_unit_iter_core.sv - one shift-add multiply or restoring-divide step
// Multiply keeps the multiplier in acc low half; divide keeps the dividend/quotient there.
module mips_muldiv_unit_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH:0]       rem_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH:0]       rem_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
  assign shifted = {rem_i[WIDTH-1:0], acc_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_i};

  always_comb begin
    acc_o = acc_i;
    rem_o = rem_i;
    if (div_mode_i) begin
      // diff MSB clear means the trial subtraction did not underflow
      if (!diff[WIDTH]) begin
        rem_o = diff;
        acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        rem_o = shifted;
        acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit owning HI/LO
// MULDIV_FAST_MULT_EN: multiply completes in one cycle with '*'; divide stays iterative.
module mips_muldiv_unit
  import mips_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign sign_a = md_op_signed(op) & rs_val[WIDTH-1];
  assign sign_b = md_op_signed(op) & rt_val[WIDTH-1];
  assign mag_a  = sign_a ? -rs_val : rs_val;
  assign mag_b  = sign_b ? -rt_val : rt_val;

  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = rem_q[WIDTH-1:0];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = md_op_signed(op) ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
  assign ext_b     = md_op_signed(op) ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
  assign fast_prod = ext_a * ext_b;
`endif

  mips_muldiv_unit_iter_core #(.WIDTH(WIDTH)) u_core (
    .div_mode_i (div_q),
    .acc_i      (acc_q),
    .rem_i      (rem_q),
    .opb_i      (opb_q),
    .acc_o      (acc_step),
    .rem_o      (rem_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              state_d = ST_RUN;
              cnt_d   = '0;
              div_d   = 1'b0;
              sa_d    = sign_a;
              sb_d    = sign_b;
              dz_d    = 1'b0;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              rem_d   = '0;
              opb_d   = mag_a;
`endif
            end
            MD_DIV, MD_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = '0;
              div_d   = 1'b1;
              sa_d    = sign_a;
              sb_d    = sign_b;
              dz_d    = (rt_val == '0);
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              rem_d   = '0;
              opb_d   = mag_b;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // remainder follows the dividend sign, which also returns rs_val on divide by zero
          lo_d = dz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
          hi_d = sa_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed and random scoreboard bench for mips_muldiv_unit
module tb_mips_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (done === 1'b1) done_cnt++;

  mips_muldiv_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    p  = 64'd0;
    eh = 32'd0;
    el = 32'd0;
    case (o)
      OP_MULT: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        eh = p[63:32];
        el = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
      default: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eh = 32'd0; el = 32'h8000_0000; end
        else begin el = $signed(a) / $signed(b); eh = $signed(a) % $signed(b); end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of cycle N+1
  task automatic launch(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit track);
    exp_t e;
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    e.hi   = eh;
    e.lo   = el;
    e.lat  = (o == OP_DIV || o == OP_DIVU) ? DIV_LAT : MUL_LAT;
    e.busy = (o == OP_DIV || o == OP_DIVU) ? DIV_BUSY : MUL_BUSY;
    if (track) begin
      sb_q.push_back(e);
      tag_q.push_back(tag);
    end
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int poke_at);
    int    lat;
    int    bcnt;
    exp_t  e;
    string t;
    lat  = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      if (lat == poke_at) begin
        start  = 1'b1;
        op     = OP_MTLO;
        rs_val = 32'hDEAD_BEEF;
      end
      @(negedge CLK);
      start = 1'b0;
      lat++;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".done_seen"}, {31'd0, done}, 32'd1);
    chk({t, ".hi"}, hi, e.hi);
    chk({t, ".lo"}, lo, e.lo);
    chk({t, ".latency"}, lat, e.lat);
    chk({t, ".busy_cycles"}, bcnt, e.busy);
    chk({t, ".busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    launch("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(0);
    chk("multu_max.hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max.lo_const", lo, 32'h0000_0001);
    @(negedge CLK);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    launch("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(0);
    chk("mult_m3x7.hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_m3x7.lo_const", lo, 32'hFFFF_FFEB);

    launch("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0);
    chk("div_m7d2.lo_const", lo, 32'hFFFF_FFFD);
    chk("div_m7d2.hi_const", hi, 32'hFFFF_FFFF);

    launch("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b1);
    wait_done(0);
    chk("divu_by0.hi_const", hi, 32'd100);
    chk("divu_by0.lo_const", lo, 32'hFFFF_FFFF);

    launch("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(0);
    chk("div_ovf.lo_const", lo, 32'h8000_0000);
    chk("div_ovf.hi_const", hi, 32'd0);

    launch("div_m5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(0);
    launch("div_7_dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(0);

    start = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("mthi.hi", hi, 32'h1234_5678);
    chk("mthi.done", {31'd0, done}, 32'd0);
    chk("mthi.busy", {31'd0, busy}, 32'd0);
    start = 1'b1; op = OP_MTLO; rs_val = 32'h9ABC_DEF0;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("mtlo.lo", lo, 32'h9ABC_DEF0);
    chk("mtlo.hi_kept", hi, 32'h1234_5678);
    chk("mtlo.done", {31'd0, done}, 32'd0);

    start = 1'b1; op = 3'd6; rs_val = 32'h5555_5555;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("reserved.hi", hi, 32'h1234_5678);
    chk("reserved.lo", lo, 32'h9ABC_DEF0);
    chk("reserved.busy", {31'd0, busy}, 32'd0);

    launch("busy_ignore", OP_DIVU, 32'd1000, 32'd7, 1'b1);
    wait_done(4);

    launch("b2b_mult", OP_MULT, 32'd6, 32'd7, 1'b1);
    wait_done(0);
    launch("b2b_divu", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1);
    wait_done(0);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : $urandom;
      launch($sformatf("rand%0d", i), ro, ra, rb, 1'b1);
      wait_done(0);
    end

    start = 1'b1; op = OP_MTHI; rs_val = 32'hCAFE_0001;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    launch("rst_mid", OP_DIVU, 32'd12345, 32'd3, 1'b0);
    repeat (9) @(negedge CLK);
    chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    d0  = done_cnt;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    chk("rst_mid.hi", hi, 32'd0);
    chk("rst_mid.lo", lo, 32'd0);
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge CLK);
    chk("rst_mid.no_done", done_cnt - d0, 32'd0);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
